// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// Holds the bus-cycle state encoding and the default wait-state count.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_STROBE = 2'd2,
    ARB_HOLD   = 2'd3
  } arb_state_t;

  localparam int DEFAULT_WAIT_STATES = 1;
  localparam int WAIT_CNT_W          = 3;

  // One-hot mask of a single port, used to exclude the current owner.
  function automatic logic [1:0] port_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin picker for the memory bus arbiter.
// Masked ports are ignored; on a tie the port not granted last wins.
module mem_bus_arbiter_rr (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output logic       gnt
);

  logic [1:0] elig;

  // Pick among eligible requesters, alternating on contention.
  always_comb begin
    elig      = req & ~mask;
    gnt_valid = |elig;
    gnt       = 1'b0;
    if (&elig) begin
      gnt = ~last_gnt;
    end else begin
      gnt = elig[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external 16-bit memory bus between the core and DMA ports.
// Each bus cycle runs SETUP, STROBE (+wait states) and HOLD, all outputs registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [1:0]        BE0,
  input  logic [1:0]        BE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA,
  input  logic [DATA_W-1:0] DIN,
  output logic [ADDR_W-1:0] ADDR_BUF,
  output logic [DATA_W-1:0] DOUT_BUF,
  output logic              RDN_BUF,
  output logic              WRN0_BUF,
  output logic              WRN1_BUF,
  output logic              ABUS_OEN,
  output logic              DBUS_OEN,
  output logic              GNT
);

  arb_state_t            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  cur_we;
  logic [1:0]            cur_be;
  logic                  last_gnt;

  logic [1:0]            arb_mask;
  logic                  win_valid;
  logic                  win;

  logic                  sel_we;
  logic [1:0]            sel_be;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  // In HOLD the current owner may not re-win the bus.
  assign arb_mask = (state == ARB_HOLD) ? port_mask(GNT) : 2'b00;

  mem_bus_arbiter_rr u_rr (
    .req       ({REQ1, REQ0}),
    .last_gnt  (last_gnt),
    .mask      (arb_mask),
    .gnt_valid (win_valid),
    .gnt       (win)
  );

  // Route the winning port's request fields toward the latch.
  always_comb begin
    sel_we    = win ? WE1    : WE0;
    sel_be    = win ? BE1    : BE0;
    sel_addr  = win ? ADDR1  : ADDR0;
    sel_wdata = win ? WDATA1 : WDATA0;
  end

  // Bus-cycle sequencer: strobes, enables, ack and read data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ARB_IDLE;
      wait_cnt <= '0;
      cur_we   <= 1'b0;
      cur_be   <= 2'b00;
      last_gnt <= 1'b1;
      GNT      <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      RDATA    <= '0;
      ADDR_BUF <= '0;
      DOUT_BUF <= '0;
      RDN_BUF  <= 1'b1;
      WRN0_BUF <= 1'b1;
      WRN1_BUF <= 1'b1;
      ABUS_OEN <= 1'b1;
      DBUS_OEN <= 1'b1;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      unique case (state)
        ARB_IDLE, ARB_HOLD: begin
          if (win_valid) begin
            GNT      <= win;
            last_gnt <= win;
            cur_we   <= sel_we;
            cur_be   <= sel_be;
            ADDR_BUF <= sel_addr;
            ABUS_OEN <= 1'b0;
            DBUS_OEN <= ~sel_we;
            if (sel_we) begin
              DOUT_BUF <= sel_wdata;
            end
            state <= ARB_SETUP;
          end else begin
            ABUS_OEN <= 1'b1;
            DBUS_OEN <= 1'b1;
            state    <= ARB_IDLE;
          end
        end
        ARB_SETUP: begin
          RDN_BUF  <= cur_we;
          WRN0_BUF <= ~(cur_we & cur_be[0]);
          WRN1_BUF <= ~(cur_we & cur_be[1]);
          wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
          state    <= ARB_STROBE;
        end
        ARB_STROBE: begin
          if (wait_cnt == '0) begin
            RDN_BUF  <= 1'b1;
            WRN0_BUF <= 1'b1;
            WRN1_BUF <= 1'b1;
            if (!cur_we) begin
              RDATA <= DIN;
            end
            ACK0  <= ~GNT;
            ACK1  <= GNT;
            state <= ARB_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Expected acks are queued at issue time and popped by an ack monitor.
module tb_mem_bus_arbiter;

  localparam int WS = 1;

  typedef struct {
    bit          port;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, REQ0_Z = 1'b0;
  logic        WE0 = 1'b0, WE1 = 1'b0;
  logic [1:0]  BE0 = 2'b11, BE1 = 2'b11;
  logic [15:0] ADDR0 = '0, ADDR1 = '0;
  logic [15:0] WDATA0 = '0, WDATA1 = '0;
  logic [15:0] DIN = '0;

  logic        ACK0, ACK1, RDN_BUF, WRN0_BUF, WRN1_BUF;
  logic        ABUS_OEN, DBUS_OEN, GNT;
  logic [15:0] RDATA, ADDR_BUF, DOUT_BUF;

  logic        z_ack0, z_ack1, z_rdn, z_wrn0, z_wrn1;
  logic        z_aoen, z_doen, z_gnt;
  logic [15:0] z_rdata, z_addr, z_dout;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.WAIT_STATES(WS)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .BE0(BE0), .BE1(BE1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .DIN(DIN),
    .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF), .RDN_BUF(RDN_BUF),
    .WRN0_BUF(WRN0_BUF), .WRN1_BUF(WRN1_BUF),
    .ABUS_OEN(ABUS_OEN), .DBUS_OEN(DBUS_OEN), .GNT(GNT)
  );

  mem_bus_arbiter #(.WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0_Z), .REQ1(1'b0), .WE0(WE0), .WE1(WE1),
    .BE0(BE0), .BE1(BE1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(z_ack0), .ACK1(z_ack1), .RDATA(z_rdata), .DIN(DIN),
    .ADDR_BUF(z_addr), .DOUT_BUF(z_dout), .RDN_BUF(z_rdn),
    .WRN0_BUF(z_wrn0), .WRN1_BUF(z_wrn1),
    .ABUS_OEN(z_aoen), .DBUS_OEN(z_doen), .GNT(z_gnt)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Ack monitor: pops the scoreboard on every ack pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        chk("rd_wr_overlap",
            32'(RDN_BUF === 1'b0 && (WRN0_BUF === 1'b0 || WRN1_BUF === 1'b0)), 0);
      end
      if (ACK0 === 1'b1 || ACK1 === 1'b1) begin
        chk("ack_onehot", 32'(ACK0 & ACK1), 0);
        if (sb.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", 32'(ACK1), 32'(e.port));
          chk("ack_gnt", 32'(GNT), 32'(e.port));
          if (e.rd) chk("rdata", 32'(RDATA), 32'(e.data));
        end
      end
    end
  end

  task automatic bus_op(input bit p, input bit we, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] din);
    exp_t e;
    int n, rdl, w0l, w1l, bad;
    logic ack;
    if (!p) begin
      WE0 = we; BE0 = be; ADDR0 = addr; WDATA0 = wdata; REQ0 = 1'b1;
    end else begin
      WE1 = we; BE1 = be; ADDR1 = addr; WDATA1 = wdata; REQ1 = 1'b1;
    end
    DIN = din;
    e.port = p; e.rd = !we; e.data = din;
    sb.push_back(e);
    n = 0; rdl = 0; w0l = 0; w1l = 0; bad = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        if (!p) begin ADDR0 = ~addr; WDATA0 = ~wdata; BE0 = ~be; end
        else    begin ADDR1 = ~addr; WDATA1 = ~wdata; BE1 = ~be; end
      end
      if (RDN_BUF === 1'b0) rdl++;
      if (WRN0_BUF === 1'b0) w0l++;
      if (WRN1_BUF === 1'b0) w1l++;
      if (ADDR_BUF !== addr || ABUS_OEN !== 1'b0) bad++;
      if (we && (DOUT_BUF !== wdata || DBUS_OEN !== 1'b0)) bad++;
      if (!we && DBUS_OEN !== 1'b1) bad++;
      ack = p ? ACK1 : ACK0;
    end while (ack !== 1'b1 && n < 20);
    chk("op_latency", n, WS + 3);
    chk("op_rdn_cycles", rdl, we ? 0 : WS + 1);
    chk("op_wrn0_cycles", w0l, (we && be[0]) ? WS + 1 : 0);
    chk("op_wrn1_cycles", w1l, (we && be[1]) ? WS + 1 : 0);
    chk("op_bus_drive", bad, 0);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    chk("op_idle_oen", {ABUS_OEN, DBUS_OEN}, 2'b11);
  endtask

  initial begin
    int n, acks, idle, rdl;
    exp_t e;

    #1 RESET = 1'b1;
    #2;
    chk("rst_strobes", {RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, DBUS_OEN}, 5'b11111);
    chk("rst_ack", {ACK0, ACK1, GNT}, 3'b000);
    chk("rst_addr", ADDR_BUF, 0);
    chk("rst_dout", DOUT_BUF, 0);
    chk("rst_rdata", RDATA, 0);
    tick();
    RESET = 1'b0;
    tick();

    bus_op(1'b0, 1'b0, 2'b11, 16'h0056, 16'h0000, 16'h3456);
    bus_op(1'b1, 1'b1, 2'b11, 16'hFAAF, 16'h0056, 16'h0000);
    bus_op(1'b0, 1'b1, 2'b10, 16'h0100, 16'hAB00, 16'h0000);
    bus_op(1'b1, 1'b1, 2'b00, 16'h0200, 16'h1234, 16'h0000);

    ADDR0 = 16'h0077; WE0 = 1'b0; BE0 = 2'b11; DIN = 16'h1111;
    REQ0 = 1'b1;
    tick();
    tick();
    chk("abort_pre_rdn", RDN_BUF, 0);
    #1 RESET = 1'b1;
    REQ0 = 1'b0;
    #1;
    chk("abort_rdn", {RDN_BUF, WRN0_BUF, WRN1_BUF}, 3'b111);
    chk("abort_oen", {ABUS_OEN, DBUS_OEN}, 2'b11);
    chk("abort_ack", {ACK0, ACK1}, 2'b00);
    tick();
    RESET = 1'b0;
    repeat (4) tick();
    bus_op(1'b0, 1'b0, 2'b11, 16'h0123, 16'h0000, 16'hBEEF);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ADDR0 = 16'h1000; ADDR1 = 16'h2000;
    WE0 = 1'b0; WE1 = 1'b0; DIN = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.rd = 1'b1; e.data = 16'hA5A5;
      sb.push_back(e);
    end
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    n = 0; acks = 0; idle = 0;
    while (acks < 4 && n < 40) begin
      tick();
      n++;
      if (ABUS_OEN !== 1'b0) idle++;
      if (ACK0 === 1'b1 || ACK1 === 1'b1) begin
        acks++;
        chk("arb_ack_time", n, acks * 4);
        if (acks == 4) begin
          REQ0 = 1'b0;
          REQ1 = 1'b0;
        end
      end
    end
    chk("arb_acks", acks, 4);
    chk("arb_no_idle", idle, 0);
    tick();
    chk("arb_release", {ABUS_OEN, DBUS_OEN}, 2'b11);

    ADDR0 = 16'h0042; WE0 = 1'b0; BE0 = 2'b11; DIN = 16'h7E57;
    REQ0_Z = 1'b1;
    n = 0; rdl = 0;
    do begin
      tick();
      n++;
      if (z_rdn === 1'b0) rdl++;
    end while (z_ack0 !== 1'b1 && n < 20);
    chk("ws0_latency", n, 3);
    chk("ws0_rdn_cycles", rdl, 1);
    chk("ws0_rdata", z_rdata, 16'h7E57);
    chk("ws0_ack1", z_ack1, 0);
    REQ0_Z = 1'b0;
    tick();
    chk("ws0_idle", {z_aoen, z_ack0}, 2'b10);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external 16-bit memory bus between two masters: port 0 (processor core fetch/load/store) and port 1 (DMA/debug loader).
- Sequences every bus cycle as SETUP, STROBE (with programmable wait states) and HOLD, driving the active-low RDN/WRN0/WRN1 strobes and the ABUS/DBUS output enables.
- Sits between the core and the pad buffers.

Parameters:
- WAIT_STATES, 1, extra STROBE cycles beyond the first (0..7).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ0/REQ1  in  1  bus request per port; held until that port's ACK.
- WE0/WE1  in  1  1 = write, 0 = read.
- BE0/BE1  in  2  byte enables; bit0 = low byte, bit1 = high byte.
- ADDR0/ADDR1  in  ADDR_W  address per port.
- WDATA0/WDATA1  in  DATA_W  write data per port.
- ACK0/ACK1  out  1  one-cycle completion pulse.
- RDATA  out  DATA_W  read data, valid while ACKn=1.
- DIN  in  DATA_W  data from the pad input buffer.
- ADDR_BUF  out  ADDR_W  external address.
- DOUT_BUF  out  DATA_W  external write data.
- RDN_BUF  out  1  read strobe, active low.
- WRN0_BUF/WRN1_BUF  out  1  low/high byte write strobes, active low.
- ABUS_OEN  out  1  address bus output enable, active low.
- DBUS_OEN  out  1  data bus output enable, active low.
- GNT  out  1  port currently owning the bus; meaningful when state is not IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, RDN_BUF=WRN0_BUF=WRN1_BUF=1, ABUS_OEN=DBUS_OEN=1, ACK0=ACK1=0, ADDR_BUF=DOUT_BUF=RDATA=0, GNT=0, priority pointer=port 0.
- All outputs are registered. Reset asserted mid-cycle aborts the cycle: strobes go high immediately and no ACK is issued.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If any REQ is high, latch the winner's ADDR/WE/BE/WDATA, set GNT, go to SETUP.
  - Both requesting: the port not granted last wins. After reset, port 0 wins.
- SETUP (1 cycle):
  - ADDR_BUF valid, ABUS_OEN=0.
  - For writes, DOUT_BUF valid and DBUS_OEN=0.
  - Strobes stay high.
- STROBE (WAIT_STATES+1 cycles, counted by a wait counter):
  - Read: RDN_BUF=0.
  - Write: WRN0_BUF=~BE[0], WRN1_BUF=~BE[1].
  - On the last STROBE edge, a read latches DIN into RDATA.
- HOLD (1 cycle):
  - Strobes high; address, data and OENs held.
  - ACKn=1 for the granted port only.
  - Arbitration in HOLD considers only the other port. If it requests, go straight to SETUP with new latched inputs. Otherwise go to IDLE, releasing OENs to 1.
  - The granted port therefore cannot hold the bus for back-to-back cycles; its REQ still being high in HOLD is ignored.
- Latency: REQ sampled at edge k gives ACK high during the cycle after edge k+WAIT_STATES+2 (WAIT_STATES=1: 4 cycles).
- A write with BE=00 runs a full cycle with no WRN strobe and still ACKs.
- Inputs change while REQ is high: ignored after latching.
- REQ dropped before ACK: illegal. The cycle completes regardless and ACKs.
- WAIT_STATES=0: exactly one STROBE cycle.
- Strobes never glitch: each changes only on state edges. RDN and WRN are never low simultaneously.

Decomposition:
- constants.v gains the state encodings (ARB_IDLE, ARB_SETUP, ARB_STROBE, ARB_HOLD) and the default wait-state count.
- A 2-way round-robin picker, bus_rr_arbiter2 (inputs: req[1:0], last grant, HOLD-exclusion mask; output: grant), is a natural sub-module.
- Wait counter and strobe generation stay inline.

Test Plan:
- Reset, then REQ0=1, WE0=0, ADDR0=0x0056, DIN=0x3456, WAIT_STATES=1 -> SETUP then 2 cycles of RDN_BUF=0 at ADDR_BUF=0x0056; ACK0 pulses 1 cycle with RDATA=0x3456; WRN0/WRN1 stay 1; return to IDLE with ABUS_OEN=1.
- REQ1 write, ADDR1=0xFAAF, WDATA1=0x0056, BE1=11 -> DOUT_BUF=0x0056, DBUS_OEN=0, WRN0_BUF=WRN1_BUF=0 for 2 cycles; ACK1 only; ACK0 stays 0.
- Byte write BE0=10 -> only WRN1_BUF=0; WRN0_BUF stays 1.
- REQ0 and REQ1 asserted in the same cycle, both held -> grant order 0, 1, 0, 1 with no IDLE between cycles; ACKs alternate every 4 cycles.
- RESET pulsed during STROBE of a read -> RDN_BUF=1 and OENs=1 immediately; no ACK; next REQ0 is serviced normally from IDLE.
- WAIT_STATES=0 build, REQ0 read -> RDN_BUF low exactly 1 cycle; ACK0 three cycles after the request edge.
